// File: rtl/seq_det_pkg.sv
// Shared constants, width helper, length clamp and fill-state decode for the
// parametrised sequence detector.
package seq_det_pkg;

  localparam int         DEF_MAX_LEN   = 8;
  localparam logic [7:0] DEF_PATTERN_C = 8'b0000_1011;
  localparam int         DEF_LEN_C     = 5;
  localparam logic       DEF_OVERLAP_C = 1'b1;
  localparam int         DEF_CNT_W     = 8;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    ARMED
  } fill_state_e;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // A zero length would never match, so it is promoted to a single-bit pattern.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// History shift register and saturating fill counter for the sequence detector.
// The newest stream bit enters at the LSB.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = len_w(DEF_MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic               restart,
  input  logic               x,
  output logic [MAX_LEN-2:0] hist,
  output logic [LEN_W-1:0]   fill
);

  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] shifted;

  // A restart only zeroes the fill count; the shift still happens so the bit
  // that completed the match stays in the history.
  always_comb begin
    shifted = {hist_q, x};
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = shifted[MAX_LEN-2:0];
      if (restart) begin
        fill_d = '0;
      end else if (fill_q != LEN_W'(MAX_LEN)) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist = hist_q;
  assign fill = fill_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector: Mealy match Z, registered Z_q
// and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = DEF_MAX_LEN,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
  parameter int                 DEF_LEN     = DEF_LEN_C,
  parameter logic               DEF_OVERLAP = DEF_OVERLAP_C,
  parameter int                 CNT_W       = DEF_CNT_W,
  localparam int                LEN_W       = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               X,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               Z,
  output logic               Z_q,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LEN_W-1:0]   fill
);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               zq_q, zq_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill_w;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic               pat_match;
  logic               z;
  fill_state_e        fill_state;

  seq_det_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .clr     (cfg_load),
    .restart (z & ~ovl_q),
    .x       (X),
    .hist    (hist),
    .fill    (fill_w)
  );

  // Only the low len_q bits of the window take part in the comparison.
  always_comb begin
    window   = {hist, X};
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end
    pat_match = ((window ^ pat_q) & len_mask) == '0;
  end

  always_comb begin
    fill_state = EMPTY;
    if (fill_w >= len_q - LEN_W'(1)) begin
      fill_state = ARMED;
    end else if (fill_w != '0) begin
      fill_state = PARTIAL;
    end
  end

  // Reset is gated like a load so nothing fires while state is being cleared.
  assign z = en & ~cfg_load & ~reset & (fill_state == ARMED) & pat_match;

  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    zq_d  = z;
    cnt_d = cnt_q;
    if (cfg_load) begin
      pat_d = cfg_pattern;
      len_d = LEN_W'(clamp_len(32'(cfg_len), 32'(MAX_LEN)));
      ovl_d = cfg_overlap;
      zq_d  = 1'b0;
      cnt_d = '0;
    end else if (z && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= DEF_PATTERN;
      len_q <= LEN_W'(DEF_LEN);
      ovl_q <= DEF_OVERLAP;
      zq_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      zq_q  <= zq_d;
      cnt_q <= cnt_d;
    end
  end

  assign Z         = z;
  assign Z_q       = zq_q;
  assign match_cnt = cnt_q;
  assign fill      = fill_w;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param with hand-computed expected values,
// built with a 2-bit counter so saturation is reachable.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk;
  logic               reset;
  logic               en;
  logic               X;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               Z;
  logic               Z_q;
  logic [CNT_W-1:0]   match_cnt;
  logic [LEN_W-1:0]   fill;

  int checks   = 0;
  int failures = 0;

  seq_detector_param #(
    .MAX_LEN     (MAX_LEN),
    .DEF_PATTERN (8'b0000_1011),
    .DEF_LEN     (5),
    .DEF_OVERLAP (1'b1),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .X           (X),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .Z           (Z),
    .Z_q         (Z_q),
    .match_cnt   (match_cnt),
    .fill        (fill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Inputs change on the falling edge; Z is sampled 1 ns later, well before
  // the next rising edge.
  task automatic applyStimulus(input string tag, input logic rst,
                               input logic ld, input logic e, input logic x,
                               input logic exp_z);
    @(negedge clk);
    reset    = rst;
    cfg_load = ld;
    en       = e;
    X        = x;
    #1;
    checkOutput(tag, 32'(Z), 32'(exp_z));
  endtask

  task automatic idleCycle();
    @(negedge clk);
    reset    = 1'b0;
    cfg_load = 1'b0;
    en       = 1'b0;
    X        = 1'b0;
    #1;
  endtask

  // Bits go out MSB first; exp_z holds the expected Z at the same index.
  task automatic sendBits(input string tag, input logic [15:0] bits,
                          input logic [15:0] exp_z, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus($sformatf("%s_b%0d", tag, n - i), 1'b0, 1'b0, 1'b1,
                    bits[i], exp_z[i]);
    end
  endtask

  task automatic setConfig(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                           input logic o);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    X        = 1'b0;
    cfg_load = 1'b0;
    setConfig(8'h00, 4'd0, 1'b0);

    $display("[TB] reset state");
    applyStimulus("rst_z0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus("rst_z1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_zq", 32'(Z_q), 32'd0);
    checkOutput("rst_cnt", 32'(match_cnt), 32'd0);
    checkOutput("rst_fill", 32'(fill), 32'd0);

    $display("[TB] default pattern 01011");
    sendBits("t1", 16'b01011, 16'b00001, 5);
    idleCycle();
    checkOutput("t1_zq", 32'(Z_q), 32'd1);
    checkOutput("t1_cnt", 32'(match_cnt), 32'd1);
    checkOutput("t1_fill", 32'(fill), 32'd5);

    $display("[TB] enable gap");
    applyStimulus("t2_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendBits("t2a", 16'b01, 16'b00, 2);
    applyStimulus("t2_gap1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_fill_gap1", 32'(fill), 32'd2);
    applyStimulus("t2_gap2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_fill_gap2", 32'(fill), 32'd2);
    sendBits("t2b", 16'b011, 16'b001, 3);
    idleCycle();
    checkOutput("t2_cnt", 32'(match_cnt), 32'd1);

    $display("[TB] pattern 101 overlapping");
    setConfig(8'b101, 4'd3, 1'b1);
    applyStimulus("t3_load", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    sendBits("t3", 16'b10101, 16'b00101, 5);
    idleCycle();
    checkOutput("t3_cnt", 32'(match_cnt), 32'd2);
    checkOutput("t3_zq", 32'(Z_q), 32'd1);

    $display("[TB] pattern 101 non-overlapping");
    setConfig(8'b101, 4'd3, 1'b0);
    applyStimulus("t3n_load", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    sendBits("t3n", 16'b10101, 16'b00100, 5);
    idleCycle();
    checkOutput("t3n_cnt", 32'(match_cnt), 32'd1);
    checkOutput("t3n_zq", 32'(Z_q), 32'd0);
    checkOutput("t3n_fill", 32'(fill), 32'd2);

    $display("[TB] load discards stream bit");
    applyStimulus("t4_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendBits("t4a", 16'b010, 16'b000, 3);
    setConfig(8'b101, 4'd3, 1'b1);
    applyStimulus("t4_load", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idleCycle();
    checkOutput("t4_fill", 32'(fill), 32'd0);
    checkOutput("t4_cnt", 32'(match_cnt), 32'd0);
    sendBits("t4b", 16'b101, 16'b001, 3);

    $display("[TB] single-bit pattern and counter saturation");
    setConfig(8'h01, 4'd1, 1'b1);
    applyStimulus("t5_load", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    sendBits("t5", 16'b111111, 16'b111111, 6);
    idleCycle();
    checkOutput("t5_cnt", 32'(match_cnt), 32'd3);
    checkOutput("t5_zq", 32'(Z_q), 32'd1);

    $display("[TB] reset mid-stream beats load");
    applyStimulus("t6_rst0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendBits("t6a", 16'b0101, 16'b0000, 4);
    setConfig(8'b101, 4'd3, 1'b1);
    applyStimulus("t6_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    sendBits("t6b", 16'b1, 16'b0, 1);
    idleCycle();
    checkOutput("t6_fill", 32'(fill), 32'd1);
    checkOutput("t6_cnt", 32'(match_cnt), 32'd0);
    sendBits("t6c", 16'b01011, 16'b00001, 5);
    idleCycle();
    checkOutput("t6_cnt2", 32'(match_cnt), 32'd1);

    $display("[TB] length clamping");
    setConfig(8'hAB, 4'd0, 1'b1);
    applyStimulus("t7_load0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    sendBits("t7a", 16'b1101, 16'b1101, 4);
    setConfig(8'hB5, 4'd15, 1'b1);
    applyStimulus("t7_load15", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    sendBits("t7b", 16'hB5, 16'h01, 8);
    idleCycle();
    checkOutput("t7_cnt", 32'(match_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector, the generalised successor to the fixed 5-bit "01011" Mealy detector. The target pattern, its length (1..MAX_LEN) and overlap mode are runtime-loadable configuration. The block provides a same-cycle Mealy match output, a registered copy and a saturating match counter. It sits on a serial bit stream qualified by `en` and feeds match strobes to downstream control/statistics logic.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits (≥2).
- `DEF_PATTERN`, 8'b0000_1011: reset pattern, LSB-aligned (with DEF_LEN=5 gives "01011").
- `DEF_LEN`, 5: reset pattern length, 1..MAX_LEN.
- `DEF_OVERLAP`, 1'b1: reset overlap mode.
- `CNT_W`, 8: match counter width.

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  X is a valid stream bit this cycle.
- `X`  in  1  serial data bit.
- `cfg_load`  in  1  load configuration this cycle.
- `cfg_pattern`  in  MAX_LEN  new pattern, LSB-aligned.
- `cfg_len`  in  $clog2(MAX_LEN+1)  new length.
- `cfg_overlap`  in  1  1 = overlapping matches, 0 = restart after match.
- `Z`  out  1  Mealy match, combinational.
- `Z_q`  out  1  Z registered.
- `match_cnt`  out  CNT_W  saturating count of matches.
- `fill`  out  $clog2(MAX_LEN+1)  valid history bits (debug/state).

## Operation
- Config registers pat_r, len_r, ovl_r; reset to DEF_PATTERN, DEF_LEN, DEF_OVERLAP.
- Bit order: pattern bit len_r-1 is received first and bit 0 last. "01011" means stream 0,1,0,1,1.
- History hist[MAX_LEN-2:0]: shift left, new bit enters LSB. window = {hist, X}, low len_r bits compared.
- States by fill: EMPTY (fill=0), PARTIAL (0<fill<len_r-1), ARMED (fill≥len_r-1).
- Z = en & ~cfg_load & ARMED & (window[len_r-1:0] == pat_r[len_r-1:0]). For len_r=1, Z = en & (X == pat_r[0]).
- On an en cycle, hist shifts and fill increments, saturating at MAX_LEN.
- On a match with ovl_r=0, fill is forced to 0 and the hist shift still occurs.
- en=0 cycles hold all stream state. X is ignored and Z=0.
- cfg_load takes priority over en. It loads the config, clears hist, fill, match_cnt and Z_q, and the stream bit in that cycle is discarded.
- Length clamp at load: cfg_len=0 loads as 1; cfg_len>MAX_LEN loads as MAX_LEN. Pattern bits above len_r are don't-care.
- match_cnt increments on each Z=1 and holds at all-ones.

## Timing
- Z is valid in the same cycle as the final pattern bit (zero latency). Z_q follows one cycle later. match_cnt updates at the edge that ends the match cycle.
- Reset values: Z_q=0, match_cnt=0, fill=0, hist=0, config = defaults. Z=0 during reset because the reset cycle is treated like cfg_load for Z gating.
- Reset and cfg_load in the same cycle: reset wins, and config returns to defaults.
- Reset mid-stream discards partial progress. No match can fire until len_r new bits have been received.
- Back-to-back matches are possible every cycle when ovl_r=1 (e.g. pattern "1", len 1).

## Structure
- Package `seq_det_pkg`:
  - default constants;
  - `LEN_W` width helper;
  - `clamp_len` function;
  - enum {EMPTY, PARTIAL, ARMED} for debug decode.
- Sub-module `seq_det_window`: hist shift register plus fill counter, with `en`, `clr`, `restart` inputs.
- The top level holds the config registers, the comparator/mask, Z_q and the counter.

## Test plan
- Defaults, en=1, stream 0,1,0,1,1 -> Z=1 on 5th bit only; Z_q=1 the next cycle; match_cnt=1.
- Stream 0,1,[en=0, X=1],0,1,1 -> exactly one match, on the final bit; the gap cycle has no effect and fill holds at 2.
- cfg_load pattern 3'b101, len 3, overlap=1; stream 1,0,1,0,1 -> Z on bits 3 and 5; match_cnt=2. Repeat with overlap=0 -> Z on bit 3 only; match_cnt=1.
- Defaults; send 0,1,0; then cfg_load 3'b101/len 3 with X=1 -> fill=0, no Z on the load cycle; then 1,0,1 -> Z on 3rd bit.
- CNT_W=2, pattern "1", len 1, six X=1 bits -> Z high for 6 cycles; match_cnt sticks at 3.
- Defaults; send 0,1,0,1, then assert reset; after release send 1 -> Z=0; fill=1; config = defaults. Also: cfg_len=0, pattern bit0=1 -> len_r=1, every X=1 matches.
